// File: rtl/bh_uart_pkg.sv
// -----------------------------------------------------------------------------
// bh_uart_pkg
// Shared types and constants for the UART transmit scheduler.
//   state_t          : scheduler states (IDLE, LOAD, WAIT)
//   FRAME_BITS       : bits per UART frame (start + 8 data + stop)
//   DEFAULT_CLK_FREQ : default system clock frequency in Hz
//   DEFAULT_BAUD     : default UART bit rate
//   onehot_to_idx()  : encodes a 4-bit one-hot vector into a 2-bit index
// -----------------------------------------------------------------------------
package bh_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam int FRAME_BITS       = 10;
   localparam int DEFAULT_CLK_FREQ = 50_000_000;
   localparam int DEFAULT_BAUD     = 115_200;

   function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/bh_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bh_rr_arbiter
// Combinational 4-way round-robin pick. The search starts at the requester
// after the last grant and wraps, so the last-granted requester has the lowest
// priority.
//   req   : request vector
//   last  : index of the previously granted requester
//   grant : one-hot pick (all zero when no request)
//   any   : at least one request present
// -----------------------------------------------------------------------------
module bh_rr_arbiter (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [3:0] grant,
   output logic       any
);

   always_comb begin
      logic       found;
      logic [1:0] idx;
      // NOTE: every output gets a default before any conditional assignment,
      // otherwise the unassigned paths infer latches.
      grant = '0;
      found = 1'b0;
      idx   = '0;
      // k = 4 wraps back to 'last' itself, checked last.
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/bh_tx_sched.sv
// -----------------------------------------------------------------------------
// bh_tx_sched
// Round-robin scheduler feeding a single UART transmitter from four byte
// requesters. One byte is granted, launched with a one-cycle start pulse and
// then the block waits a full frame (plus idle gap) before the next grant.
//   sys_clk   : clock, rising edge
//   sys_rst   : asynchronous active-high reset (synchronised release)
//   tx_enable : allows new grants (an in-flight frame always completes)
//   req_valid : per-requester byte valid
//   req_data  : requester i byte on [8i+7:8i]
//   req_ready : one-hot accept strobe, combinational in IDLE
//   uart_en   : one-cycle start pulse to the UART transmitter
//   uart_din  : byte to transmit, held until the next launch
//   busy      : high while a frame is being launched or timed
//   grant_id  : index of the last granted requester
// -----------------------------------------------------------------------------
module bh_tx_sched
   import bh_uart_pkg::*;
#(
   parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
   parameter int BAUD     = DEFAULT_BAUD,
   parameter int GAP_BITS = 1
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        tx_enable,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ready,
   output logic        uart_en,
   output logic [7:0]  uart_din,
   output logic        busy,
   output logic [1:0]  grant_id
);

   localparam int FRAME_CYCLES = (CLK_FREQ / BAUD) * (FRAME_BITS + GAP_BITS);
   localparam int CNT_W        = ($clog2(FRAME_CYCLES) > 0) ? $clog2(FRAME_CYCLES) : 1;

   generate
      if (FRAME_CYCLES < 2) begin : g_bad_frame
         $error("bh_tx_sched: FRAME_CYCLES must be at least 2");
      end
   endgenerate

   // Reset asserts immediately but releases two clock edges later, so every
   // flop leaves reset on the same clean edge.
   logic [1:0] rst_sync;
   logic       rst_int;

   // NOTE: sequential state uses non-blocking assignments so all flops sample
   // their inputs from the same edge regardless of statement order.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) rst_sync <= 2'b11;
      else         rst_sync <= {rst_sync[0], 1'b0};
   end

   assign rst_int = rst_sync[1];

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       arb_grant;
   logic             arb_any;
   logic             grant_now;
   logic [1:0]       grant_idx;

   bh_rr_arbiter u_arb (
      .req   (req_valid),
      .last  (grant_id),
      .grant (arb_grant),
      .any   (arb_any)
   );

   // rst_int is included so ready stays low until the synchroniser releases.
   assign grant_now = (state == ST_IDLE) && tx_enable && arb_any && !rst_int;
   assign req_ready = grant_now ? arb_grant : 4'b0000;
   assign grant_idx = onehot_to_idx(arb_grant);

   always_ff @(posedge sys_clk or posedge rst_int) begin
      if (rst_int) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         uart_en  <= 1'b0;
         uart_din <= 8'h00;
         busy     <= 1'b0;
         grant_id <= 2'd3;
      end else begin
         uart_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_now) begin
                  // Registered here so uart_en/uart_din are valid throughout LOAD.
                  uart_din <= req_data[{grant_idx, 3'b000} +: 8];
                  grant_id <= grant_idx;
                  uart_en  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               cnt   <= CNT_W'(FRAME_CYCLES - 1);
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // Counts FRAME_CYCLES-1 down to 0: exactly FRAME_CYCLES WAIT cycles.
               if (cnt == '0) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bh_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_bh_tx_sched
// Self-checking bench for bh_tx_sched (CLK_FREQ=1 MHz, BAUD=100 kHz,
// GAP_BITS=1 -> 110-cycle frames). A cycle-level reference model derived from
// the timing rules (grant at T: pulse at T+1, busy T+1..T+1+F, next grant no
// earlier than T+2+F; round-robin from grant_id+1) predicts every output each
// cycle. Inputs change 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_bh_tx_sched;

   localparam int  CLK_FREQ = 1_000_000;
   localparam int  BAUD     = 100_000;
   localparam int  GAP_BITS = 1;
   localparam longint F     = (CLK_FREQ / BAUD) * (10 + GAP_BITS);

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  valid;
   logic [31:0] data;
   logic [3:0]  req_ready;
   logic        uart_en;
   logic [7:0]  uart_din;
   logic        busy;
   logic [1:0]  grant_id;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   longint     cyc        = 0;
   longint     gnt_cyc    = -1000;
   longint     ready_from = 0;
   logic [1:0] m_gid      = 2'd3;
   logic [7:0] m_din      = 8'h00;

   always #5 clk = ~clk;

   bh_tx_sched #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .GAP_BITS (GAP_BITS)
   ) dut (
      .sys_clk   (clk),
      .sys_rst   (rst),
      .tx_enable (en),
      .req_valid (valid),
      .req_data  (data),
      .req_ready (req_ready),
      .uart_en   (uart_en),
      .uart_din  (uart_din),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: predict, compare, advance the model.
   task automatic step();
      logic [3:0] e_ready;
      int         idx;
      @(negedge clk);
      e_ready = '0;
      idx     = 0;
      if (rst) begin
         check("rst_ready", 32'(req_ready), 32'h0);
         check("rst_uart_en", 32'(uart_en), 32'h0);
         check("rst_busy", 32'(busy), 32'h0);
         check("rst_uart_din", 32'(uart_din), 32'h0);
         check("rst_grant_id", 32'(grant_id), 32'h3);
         m_gid      = 2'd3;
         m_din      = 8'h00;
         gnt_cyc    = -1000;
         // Release is seen one cycle later, then two synchroniser edges.
         ready_from = cyc + 3;
      end else begin
         if (cyc >= ready_from && en && valid != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
               idx = (int'(m_gid) + k) % 4;
               if (valid[idx]) begin
                  e_ready[idx] = 1'b1;
                  break;
               end
            end
         end
         check("req_ready", 32'(req_ready), 32'(e_ready));
         check("uart_en", 32'(uart_en), 32'(cyc == gnt_cyc + 1));
         check("busy", 32'(busy), 32'(cyc >= gnt_cyc + 1 && cyc <= gnt_cyc + 1 + F));
         check("uart_din", 32'(uart_din), 32'(m_din));
         check("grant_id", 32'(grant_id), 32'(m_gid));
         if (e_ready != 4'b0000) begin
            m_gid      = 2'(idx);
            m_din      = data[8*idx +: 8];
            gnt_cyc    = cyc;
            ready_from = cyc + 2 + F;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst   = 1'b1;
      en    = 1'b0;
      valid = 4'b0000;
      data  = 32'h0;
      @(posedge clk);
      #1;

      // Reset state, then a single request from requester 0.
      run(3);
      rst = 1'b0;
      run(4);
      en    = 1'b1;
      valid = 4'b0001;
      data  = 32'h0000_0041;
      step();
      valid = 4'b0000;
      run(int'(F) + 5);

      // All four requesters continuously valid after a fresh reset.
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      run(3);
      valid = 4'b1111;
      data  = 32'h1312_1110;
      run(5 * (int'(F) + 2));
      valid = 4'b0000;
      run(int'(F) + 3);

      // tx_enable low blocks grants; raising it grants in the same cycle.
      en    = 1'b0;
      valid = 4'b0100;
      data  = 32'h00AA_0000;
      run(50);
      en = 1'b1;
      step();
      valid = 4'b0000;
      run(int'(F) + 3);

      // Reset in the middle of a frame, then requesters 0 and 1 compete.
      valid = 4'b0001;
      data  = 32'h0000_005A;
      step();
      valid = 4'b0000;
      run(50);
      valid = 4'b0011;
      data  = 32'h0000_3C5A;
      rst   = 1'b1;
      run(2);
      rst = 1'b0;
      run(5);
      valid = 4'b0000;
      run(int'(F) + 3);

      // Requester 3 valid only during WAIT: no grant, grant_id unchanged.
      valid = 4'b0001;
      data  = 32'h0000_0077;
      step();
      valid = 4'b0000;
      run(30);
      valid = 4'b1000;
      data  = 32'h9900_0000;
      run(60);
      valid = 4'b0000;
      run(int'(F));

      // Randomised traffic, enable toggling and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if (i % 4 == 0) valid = 4'($urandom);
         data = $urandom;
         en   = ($urandom_range(7, 0) != 0);
         rst  = ($urandom_range(599, 0) == 0);
         step();
      end
      rst   = 1'b0;
      valid = 4'b0000;
      run(int'(F) + 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bh_tx_sched.md
BH_TX_SCHED -- requirements
Module: bh_tx_sched

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: UART bit rate.
REQ-003 SHALL have parameter GAP_BITS, default 1: idle bit-times inserted after each frame.
REQ-004 SHALL have port sys_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port tx_enable, input, 1: when high, new grants are allowed.
REQ-007 SHALL have port req_valid, input, 4: per-requester byte-valid.
REQ-008 SHALL have port req_data, input, 32: requester i byte on bits [8i+7:8i].
REQ-009 SHALL have port req_ready, output, 4: one-hot accept strobe.
REQ-010 SHALL have port uart_en, output, 1: one-cycle start pulse to the UART transmitter.
REQ-011 SHALL have port uart_din, output, 8: byte to transmit.
REQ-012 SHALL have port busy, output, 1: high while a frame is being launched or timed.
REQ-013 SHALL have port grant_id, output, 2: index of the last granted requester.

Function
REQ-014 SHALL define FRAME_CYCLES = (CLK_FREQ/BAUD)*(10+GAP_BITS), using integer division, and SHALL fail elaboration if FRAME_CYCLES < 2.
REQ-015 SHALL implement states IDLE, LOAD and WAIT; busy SHALL equal (state != IDLE), registered.
REQ-016 In IDLE with tx_enable=1 and any req_valid bit set, the block SHALL combinationally assert req_ready[i] for exactly one i.
  - i is the first valid requester in round-robin order starting at grant_id+1 (mod 4).
REQ-017 On that grant cycle the block SHALL latch req_data[i] and set grant_id to i, then go to LOAD.
REQ-018 req_ready SHALL be 0 in LOAD and WAIT, and 0 whenever tx_enable=0 or req_valid=0.
REQ-019 In LOAD (one cycle) the block SHALL drive uart_en=1 and uart_din to the latched byte, load the frame counter with FRAME_CYCLES-1, and go to WAIT.
REQ-020 In WAIT the block SHALL decrement the counter each cycle and go to IDLE in the cycle after the counter reads 0, giving exactly FRAME_CYCLES WAIT cycles.
REQ-021 Timing SHALL be as follows for a grant at cycle T:
  - uart_en high at T+1 only;
  - busy high from T+1 to T+1+FRAME_CYCLES;
  - earliest next grant at T+2+FRAME_CYCLES.
REQ-022 uart_din SHALL hold its value from LOAD until the next LOAD.
REQ-023 tx_enable falling in LOAD or WAIT SHALL NOT abort the frame; it only blocks the next grant.
REQ-024 A requester deasserting valid before it is granted SHALL lose its turn, with no side effects.
REQ-025 Requesters SHALL hold data stable while valid; a byte is transferred only on the cycle where valid and ready are both high.

Reset
REQ-026 While sys_rst=1 the block SHALL hold the following, including mid-frame:
  - state=IDLE, counter=0, uart_en=0, uart_din=8'h00, busy=0;
  - grant_id=2'd3, so requester 0 has first priority;
  - req_ready=0.
REQ-027 Reset SHALL take effect immediately (asynchronous) and release synchronously to sys_clk through a two-flop deassertion synchronizer.

Structure
REQ-028 Package bh_uart_pkg SHALL hold the state enum, FRAME_BITS=10 and the default CLK_FREQ/BAUD constants.
REQ-029 The round-robin pick SHALL be a combinational sub-module bh_rr_arbiter (inputs: 4-bit request, 2-bit last grant; outputs: one-hot grant, any).

Verification (CLK_FREQ=1_000_000, BAUD=100_000, GAP_BITS=1 -> FRAME_CYCLES=110)
REQ-030 After reset, req_valid=4'b0001 with byte 0x41 at cycle T -> req_ready=4'b0001 at T, uart_en=1 and uart_din=0x41 at T+1, busy high T+1..T+111, busy low at T+112.
REQ-031 All four valid continuously with bytes 0x10..0x13 -> grants in order 0,1,2,3,0, spaced 112 cycles, with uart_din sequence 0x10,0x11,0x12,0x13,0x10.
REQ-032 tx_enable=0 with req_valid=4'b0100 for 50 cycles -> no req_ready and no uart_en; tx_enable=1 -> req_ready[2] in that same cycle, uart_en next cycle.
REQ-033 sys_rst pulse at T+50 of a frame -> uart_en, busy and uart_din become 0 immediately; after release with requesters 0 and 1 valid -> requester 0 is granted first.
REQ-034 Requester 3 valid during WAIT but dropped before IDLE -> no grant and no uart_en; grant_id unchanged.
